// File: rtl/mem_port_arbiter_if.sv
// Request/response channels for the fetch and load/store requesters plus the RAM port.
// The arbiter uses the slave modport; the core/RAM side uses master.
interface mem_port_arbiter_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic        if_rsp_ready;
    logic [31:0] if_rsp_rdata;
    logic        if_rsp_err;

    logic        d_req_valid;
    logic        d_req_ready;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid;
    logic        d_rsp_ready;
    logic [31:0] d_rsp_rdata;
    logic        d_rsp_err;

    logic [31:0] mem_addr;
    logic        mem_r_enable;
    logic        mem_w_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_req_addr, if_rsp_ready,
        output if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
        output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
        output mem_addr, mem_r_enable, mem_w_enable, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req_valid, if_req_addr, if_rsp_ready,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
        input  mem_addr, mem_r_enable, mem_w_enable, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares the single-ported data RAM between fetch and load/store, one access in flight (MEM_ARB_MISALIGN_CHK_EN adds misalignment errors).
// Latency: request accepted in cycle N, response valid in cycle N+1; back-to-back gives one access per cycle.
// Backpressure: a held response blocks all new grants; a new grant is only taken in the cycle that response handshakes.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_D  = 2'd2;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [3:0]  streak;
    logic [3:0]  streak_nxt;
    logic        rsp_zero;
    logic        rsp_zero_nxt;
    logic        can_accept;
    logic        starved;
    logic        grant_if;
    logic        grant_d;
    logic        granted;
    logic [31:0] grant_addr;
    logic        misaligned;
    logic        busy_if;
    logic        busy_d;

    assign busy_if = (state == ST_BUSY_IF);
    assign busy_d  = (state == ST_BUSY_D);

    // A new access may start when idle or when the pending response leaves this cycle.
    always_comb begin
        can_accept = 1'b0;
        case (state)
            ST_IDLE:    can_accept = 1'b1;
            ST_BUSY_IF: can_accept = bus.if_rsp_ready;
            ST_BUSY_D:  can_accept = bus.d_rsp_ready;
            default:    can_accept = 1'b0;
        endcase
        can_accept = can_accept && rst_n;
    end

    assign starved  = bus.if_req_valid && (streak == LIMIT);
    assign grant_d  = can_accept && bus.d_req_valid && !starved;
    assign grant_if = can_accept && bus.if_req_valid && !grant_d;
    assign granted  = grant_if || grant_d;

    always_comb begin
        grant_addr = 32'h0;
        if (grant_if) begin
            grant_addr = bus.if_req_addr;
        end else if (grant_d) begin
            grant_addr = bus.d_req_addr;
        end
    end

`ifdef MEM_ARB_MISALIGN_CHK_EN
    logic rsp_err;
    logic rsp_err_nxt;

    assign misaligned = granted && (grant_addr[1:0] != 2'b00);

    always_comb begin
        rsp_err_nxt = rsp_err;
        if (granted) begin
            rsp_err_nxt = misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= rsp_err_nxt;
        end
    end

    assign bus.if_rsp_err = busy_if && rsp_err;
    assign bus.d_rsp_err  = busy_d && rsp_err;
`else
    assign misaligned     = 1'b0;
    assign bus.if_rsp_err = 1'b0;
    assign bus.d_rsp_err  = 1'b0;
`endif

    // RAM port is only driven in the accept cycle; a rejected access still takes the slot.
    assign bus.mem_addr     = grant_addr;
    assign bus.mem_r_enable = !misaligned && (grant_if || (grant_d && !bus.d_req_we));
    assign bus.mem_w_enable = !misaligned && grant_d && bus.d_req_we;
    assign bus.mem_wdata    = granted ? bus.d_req_wdata : 32'h0;

    assign bus.if_req_ready = grant_if;
    assign bus.d_req_ready  = grant_d;

    always_comb begin
        state_nxt    = state;
        streak_nxt   = streak;
        rsp_zero_nxt = rsp_zero;
        if ((busy_if && bus.if_rsp_ready) || (busy_d && bus.d_rsp_ready)) begin
            state_nxt = ST_IDLE;
        end
        if (grant_if) begin
            state_nxt    = ST_BUSY_IF;
            streak_nxt   = 4'd0;
            rsp_zero_nxt = misaligned;
        end else if (grant_d) begin
            state_nxt    = ST_BUSY_D;
            streak_nxt   = bus.if_req_valid ? (streak + 4'd1) : 4'd0;
            rsp_zero_nxt = misaligned || bus.d_req_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            streak   <= 4'd0;
            rsp_zero <= 1'b0;
        end else begin
            state    <= state_nxt;
            streak   <= streak_nxt;
            rsp_zero <= rsp_zero_nxt;
        end
    end

    // No enable is raised while busy, so the RAM's registered output stays valid for the whole response.
    assign bus.if_rsp_valid = busy_if;
    assign bus.if_rsp_rdata = (busy_if && !rsp_zero) ? bus.mem_rdata : 32'h0;
    assign bus.d_rsp_valid  = busy_d;
    assign bus.d_rsp_rdata  = (busy_d && !rsp_zero) ? bus.mem_rdata : 32'h0;

    a_one_enable: assert property (@(posedge clk) !(bus.mem_r_enable && bus.mem_w_enable));
    a_one_ready:  assert property (@(posedge clk) !(bus.if_req_ready && bus.d_req_ready));
    a_streak_cap: assert property (@(posedge clk) disable iff (!rst_n) streak <= LIMIT);
endmodule
